// File: rtl/r8mbe_seq_mult_if.sv
`default_nettype none
// ============================================================================
// Module   : r8mbe_seq_mult_if
// Brief    : Operand/result handshake bundle for the sequential R8-MBE multiplier.
// Revision : 1.0
// ============================================================================
interface r8mbe_seq_mult_if #(
  parameter int WIDTH = 24
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a_i;
  logic [WIDTH-1:0]       b_i;
  logic                   abort;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product_o;

  modport master (
    output in_valid, a_i, b_i, abort, out_ready,
    input  in_ready, busy, out_valid, product_o
  );

  modport slave (
    input  in_valid, a_i, b_i, abort, out_ready,
    output in_ready, busy, out_valid, product_o
  );
endinterface
`default_nettype wire

// File: rtl/r8mbe_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : r8mbe_seq_mult
// Brief    : Iterative radix-8 modified-Booth 24x24 unsigned multiplier, one digit/cycle.
// Revision : 1.0
// ============================================================================
module r8mbe_seq_mult #(
  parameter int WIDTH = 24
) (
  input  logic              clk,
  input  logic              rst,
  r8mbe_seq_mult_if.slave   bus
);
  localparam int NDIG = WIDTH / 3 + 1;
  localparam int CNTW = $clog2(NDIG);
  localparam int ACCW = 2 * WIDTH + 2;
  localparam int MW   = WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [ACCW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH+2:0]     b_q, b_d;
  logic [WIDTH+1:0]     m3_q, m3_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [3:0]           w_win;
  logic                 w_neg;
  logic [2:0]           w_mag;
  logic [MW-1:0]        w_sel;
  logic [MW-1:0]        w_mult;
  logic [ACCW-1:0]      w_addend;
  logic [ACCW-1:0]      w_acc_sum;

  // Window bit 0 is the overlap bit; the extra zero covers the top digit's MSB.
  assign w_win = 4'({1'b0, b_q} >> (3 * cnt_q));

  always_comb begin
    w_neg = 1'b0;
    w_mag = 3'd0;
    case (w_win)
      4'd1, 4'd2:   w_mag = 3'd1;
      4'd3, 4'd4:   w_mag = 3'd2;
      4'd5, 4'd6:   w_mag = 3'd3;
      4'd7:         w_mag = 3'd4;
      4'd8:         begin w_neg = 1'b1; w_mag = 3'd4; end
      4'd9, 4'd10:  begin w_neg = 1'b1; w_mag = 3'd3; end
      4'd11, 4'd12: begin w_neg = 1'b1; w_mag = 3'd2; end
      4'd13, 4'd14: begin w_neg = 1'b1; w_mag = 3'd1; end
      default:      ;
    endcase
  end

  always_comb begin
    w_sel = '0;
    case (w_mag)
      3'd1:    w_sel = {3'b000, a_q};
      3'd2:    w_sel = {2'b00, a_q, 1'b0};
      3'd3:    w_sel = {1'b0, m3_q};
      3'd4:    w_sel = {1'b0, a_q, 2'b00};
      default: w_sel = '0;
    endcase
  end

  assign w_mult    = w_neg ? ((~w_sel) + MW'(1)) : w_sel;
  assign w_addend  = {{(ACCW-MW){w_mult[MW-1]}}, w_mult} << (3 * cnt_q);
  assign w_acc_sum = acc_q + w_addend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m3_q    <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m3_q    <= m3_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    m3_d    = m3_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a_i;
          b_d     = {2'b00, bus.b_i, 1'b0};
          acc_d   = '0;
          state_d = PRE;
        end
      end
      PRE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          m3_d    = {2'b00, a_q} + {1'b0, a_q, 1'b0};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          acc_d = w_acc_sum;
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(NDIG - 1)) begin
            prod_d  = w_acc_sum[2*WIDTH-1:0];
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == PRE) || (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.product_o = prod_q;

endmodule
`default_nettype wire
